// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-like to single-beat AXI3 bridge.
// Tie-off constants are consumed by the instantiating wrapper, not by the bridge.
package sram_axi_bridge_pkg;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned STRB_W   = DATA_W / 8;
   localparam int unsigned SIZE_W   = 2;
   localparam int unsigned AXSIZE_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      AR,
      R,
      AW_W,
      B
   } state_e;

   localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
   localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
   localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

   localparam logic [3:0] LEN0       = 4'd0;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [3:0] CACHE0     = 4'd0;
   localparam logic [2:0] PROT0      = 3'd0;

   // Request fields captured at the accept point
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [SIZE_W-1:0] size;
      logic [STRB_W-1:0] wstrb;
      logic [DATA_W-1:0] wdata;
   } sram_req_t;

endpackage

// File: rtl/sram_axi_bridge_if.sv
// Bus bundles for the bridge: the SRAM-like core port and the AXI3 port.
// In each interface the master modport is the side that issues requests.
interface sram_axi_bridge_sram_if;
   import sram_axi_bridge_pkg::*;

   logic                sram_req;
   logic                sram_wr;
   logic [SIZE_W-1:0]   sram_size;
   logic [ADDR_W-1:0]   sram_addr;
   logic [STRB_W-1:0]   sram_wstrb;
   logic [DATA_W-1:0]   sram_wdata;
   logic                sram_addr_ok;
   logic [DATA_W-1:0]   sram_rdata;
   logic                sram_data_ok;

   modport master (
      output sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata,
      input  sram_addr_ok, sram_rdata, sram_data_ok
   );

   modport slave (
      input  sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata,
      output sram_addr_ok, sram_rdata, sram_data_ok
   );
endinterface

interface sram_axi_bridge_axi_if;
   import sram_axi_bridge_pkg::*;

   logic [ADDR_W-1:0]   araddr;
   logic [AXSIZE_W-1:0] arsize;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic [AXSIZE_W-1:0] awsize;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [STRB_W-1:0]   wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arsize, arvalid, rready,
             awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arsize, arvalid, rready,
             awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/sram_axi_bridge.sv
// SRAM-like master port to single-beat AXI3 read/write, one transaction in flight.
// addr_ok is the only combinational output; everything else is registered.
module sram_axi_bridge
   import sram_axi_bridge_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   sram_axi_bridge_sram_if.slave  sram,
   sram_axi_bridge_axi_if.master  axi
);

   state_e             r_state;
   state_e             w_state_nxt;
   sram_req_t          r_req;
   logic [DATA_W-1:0]  r_rdata;
   logic               r_data_ok;
   logic               r_aw_done;
   logic               r_w_done;
   logic               r_arvalid;
   logic               r_rready;
   logic               r_awvalid;
   logic               r_wvalid;
   logic               r_bready;

   logic               w_accept;
   logic               w_aw_done_nxt;
   logic               w_w_done_nxt;
   logic               w_data_ok_nxt;
   logic               w_rdata_ld;
   logic               w_unused_resp;

   assign w_accept      = sram.sram_req && (r_state == IDLE);
   assign w_unused_resp = ^{axi.rresp, axi.bresp};

   // State register plus handshake flags and the valid/ready outputs they imply
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_data_ok <= 1'b0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_aw_done <= w_aw_done_nxt;
         r_w_done  <= w_w_done_nxt;
         r_data_ok <= w_data_ok_nxt;
         r_arvalid <= (w_state_nxt == AR);
         r_rready  <= (w_state_nxt == R);
         r_awvalid <= (w_state_nxt == AW_W) && !w_aw_done_nxt;
         r_wvalid  <= (w_state_nxt == AW_W) && !w_w_done_nxt;
         r_bready  <= (w_state_nxt == B);
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_aw_done_nxt = r_aw_done;
      w_w_done_nxt  = r_w_done;
      w_data_ok_nxt = 1'b0;
      w_rdata_ld    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt   = sram.sram_wr ? AW_W : AR;
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
            end
         end
         AR: begin
            if (axi.arready) w_state_nxt = R;
         end
         R: begin
            if (axi.rvalid) begin
               w_state_nxt   = IDLE;
               w_data_ok_nxt = 1'b1;
               w_rdata_ld    = 1'b1;
            end
         end
         AW_W: begin
            // AW and W retire independently; both may land in the same cycle
            w_aw_done_nxt = r_aw_done | (r_awvalid & axi.awready);
            w_w_done_nxt  = r_w_done  | (r_wvalid  & axi.wready);
            if (w_aw_done_nxt && w_w_done_nxt) w_state_nxt = B;
         end
         B: begin
            if (axi.bvalid) begin
               w_state_nxt   = IDLE;
               w_data_ok_nxt = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Request capture at accept and read-data capture at completion
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_req   <= '0;
         r_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_req <= '{addr:  sram.sram_addr,
                       size:  sram.sram_size,
                       wstrb: sram.sram_wstrb,
                       wdata: sram.sram_wdata};
         end
         if (w_rdata_ld) r_rdata <= axi.rdata;
      end
   end

   assign sram.sram_addr_ok = w_accept;
   assign sram.sram_rdata   = r_rdata;
   assign sram.sram_data_ok = r_data_ok;

   assign axi.araddr  = r_req.addr;
   assign axi.awaddr  = r_req.addr;
   assign axi.arsize  = {1'b0, r_req.size};
   assign axi.awsize  = {1'b0, r_req.size};
   assign axi.wdata   = r_req.wdata;
   assign axi.wstrb   = r_req.wstrb;
   assign axi.arvalid = r_arvalid;
   assign axi.rready  = r_rready;
   assign axi.awvalid = r_awvalid;
   assign axi.wvalid  = r_wvalid;
   assign axi.bready  = r_bready;

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Converts one SRAM-like master port (req/addr_ok/data_ok protocol) into single-beat AXI3 read and write transactions. Two instances sit directly downstream of the CPU core's inst and data SRAM-like ports, feeding the system AXI crossbar. At most one transaction is in flight per instance. Constant AXI sideband fields (id, len=0, burst=INCR, lock, cache, prot) are tied off by the instantiating wrapper and are not ports here.

Parameters:
none (address and data fixed at 32 bits)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high
sram_req  in  1  master request
sram_wr  in  1  1 = write, 0 = read
sram_size  in  2  0 = byte, 1 = half, 2 = word
sram_addr  in  32  byte address
sram_wstrb  in  4  write byte enables
sram_wdata  in  32  write data
sram_addr_ok  out  1  request accepted this cycle
sram_rdata  out  32  read data, valid with data_ok
sram_data_ok  out  1  one-cycle completion pulse (read or write)
araddr, awaddr  out  32 each  latched address
arsize, awsize  out  3 each  {1'b0, size}
arvalid / arready  out / in  1  read address handshake
rdata  in  32  read data
rresp  in  2  ignored
rvalid / rready  in / out  1  read data handshake
awvalid / awready  out / in  1  write address handshake
wdata  out  32  latched wdata
wstrb  out  4  latched wstrb
wvalid / wready  out / in  1  write data handshake
bresp  in  2  ignored
bvalid / bready  in / out  1  write response handshake

Behaviour:
- Reset (async, any state): state=IDLE; arvalid, rready, awvalid, wvalid, bready, sram_data_ok = 0; sram_rdata and latched address/data/size = 0. An in-flight AXI transaction is abandoned, because the slave is reset on the same reset.
- sram_addr_ok = sram_req & (state==IDLE). This is combinational and is the only accept point. On accept, latch addr, size, wr, wstrb and wdata.
- State IDLE: on accept, go to AR if wr=0, else AW_W.
- State AR: arvalid=1. On arready, go to R.
- State R: rready=1. On rvalid, register rdata into sram_rdata, pulse sram_data_ok the next cycle, and go to IDLE.
- State AW_W: awvalid=1 and wvalid=1 from the same cycle. Each drops independently after its own handshake (aw_done/w_done flags). When both are done, including when both handshake in the same cycle, go to B.
- State B: bready=1. On bvalid, pulse sram_data_ok the next cycle and go to IDLE.
- The data_ok cycle coincides with IDLE. A new req may therefore get addr_ok in the same cycle that data_ok pulses; this is legal.
- Minimum read latency, with arready and rvalid immediate: accept in cycle 0, arvalid in cycle 1, rready/rvalid in cycle 2, data_ok in cycle 3.
- rlast is not consumed (single beat). Non-OKAY rresp/bresp still completes normally with data_ok.
- sram_rdata holds its value until the next read completes.

Decomposition:
- Shared package: state enum {IDLE, AR, R, AW_W, B}; SIZE_BYTE/HALF/WORD constants; AXI tie-off constants (LEN0, BURST_INCR, CACHE0, PROT0), used by the wrapper.
- No sub-module: a single FSM plus latches.

Test Plan:
- Read word, addr 0xBFC00000, arready=1, rvalid in the following cycle with rdata 0x3C1D0001 -> araddr=0xBFC00000, arsize=2, sram_rdata=0x3C1D0001, data_ok in cycle 3, exactly one addr_ok.
- Write byte, addr 0x80001003, wstrb=0x8, wdata=0xAA000000; awready 2 cycles before wready -> awvalid drops after its handshake, wvalid holds until wready, bready rises only after both are done, data_ok is 1 cycle after bvalid.
- Back-to-back: req held high across two reads -> second addr_ok lands in the same cycle as the first data_ok; no lost or duplicated data_ok.
- Stalled slave: arready low for 5 cycles -> arvalid and araddr stable throughout; addr_ok stays 0 while req is held.
- Reset asserted while in R with rvalid pending -> outputs 0 within the same cycle (async); after release, state is IDLE and the next req gets addr_ok immediately.
- Half-word read, size=1, with rresp=2'b10 -> arsize=3'b001, completes with data_ok and returns rdata unchanged.
